// File: rtl/regbank_mp_pkg.sv
// Shared types and helpers for the multi-port operand register bank.
// merge_word is used by both the bank write path and the read bypass path.
package regbank_mp_pkg;

    localparam int MAXW = 1024;

    localparam logic [1:0] EM_BOTH = 2'b00;
    localparam logic [1:0] EM_LO   = 2'b01;
    localparam logic [1:0] EM_HI   = 2'b10;
    localparam logic [1:0] EM_SWAP = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } st_t;

    typedef logic [MAXW-1:0] wide_t;

    // Operates on a zero-extended word; callers truncate back to w bits.
    function automatic wide_t merge_word(
        input wide_t      old,
        input wide_t      din,
        input logic [1:0] mode,
        input int         w
    );
        wide_t lo;
        wide_t r;
        lo = (wide_t'(1) << (w / 2)) - wide_t'(1);
        case (mode)
            EM_LO:   r = (old & ~lo) | (din & lo);
            EM_HI:   r = (old & lo) | (din & ~lo);
            EM_SWAP: r = ((din & lo) << (w / 2)) | ((din >> (w / 2)) & lo);
            default: r = din;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/regbank_mp_if.sv
// Write, clear and read-port bundle of the operand register bank.
// master drives requests, slave is the bank.
interface regbank_mp_if #(
    parameter int W     = 64,
    parameter int DEPTH = 16,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(DEPTH);

    logic              regwen;
    logic [W-1:0]      inA;
    logic [AW-1:0]     selwreg;
    logic [1:0]        endreg;
    logic              cnstwen;
    logic              clr;
    logic              busy;
    logic [NRD*AW-1:0] rsel;
    logic [NRD-1:0]    rcnst;
    logic [NRD-1:0]    ren;
    logic [NRD*W-1:0]  rdata;

    modport master (
        output regwen, inA, selwreg, endreg,
        output cnstwen, clr, rsel, rcnst, ren,
        input  busy, rdata
    );

    modport slave (
        input  regwen, inA, selwreg, endreg,
        input  cnstwen, clr, rsel, rcnst, ren,
        output busy, rdata
    );

endinterface

// File: rtl/regbank_mp_rdport.sv
// One registered read port: bank/constant select, write bypass, output reg.
// Bypass compares are compiled out when BYPASS is 0.
module regbank_mp_rdport
    import regbank_mp_pkg::*;
#(
    parameter int W      = 64,
    parameter int DEPTH  = 16,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [DEPTH*W-1:0] bank_flat,
    input  logic [W-1:0]       cnst,
    input  logic [W-1:0]       cnst_new,
    input  logic               cnst_we,
    input  logic [W-1:0]       wword,
    input  logic [AW-1:0]      wsel,
    input  logic               wvalid,
    input  logic [AW-1:0]      rsel,
    input  logic               rcnst,
    input  logic               ren,
    output logic [W-1:0]       rdata
);

    logic [W-1:0] bank_word;
    logic [W-1:0] nxt;
    logic         hit_w;
    logic         hit_c;

    always_comb begin
        bank_word = bank_flat[int'(rsel) * W +: W];
        hit_w = (BYPASS != 0) && wvalid && (wsel == rsel);
        hit_c = (BYPASS != 0) && cnst_we;
        nxt   = bank_word;
        unique case (1'b1)
            rcnst && hit_c:   nxt = cnst_new;
            rcnst && !hit_c:  nxt = cnst;
            !rcnst && hit_w:  nxt = wword;
            !rcnst && !hit_w: nxt = bank_word;
            default:          nxt = bank_word;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (ren) begin
            rdata <= nxt;
        end
    end

endmodule

// File: rtl/regbank_mp.sv
// Multi-port operand register bank with half-word writes, write bypass
// and a sequenced background clear that blocks writes while busy.
module regbank_mp
    import regbank_mp_pkg::*;
#(
    parameter int W      = 64,
    parameter int DEPTH  = 16,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic          clock,
    input  logic          reset,
    regbank_mp_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);

    st_t                st;
    st_t                st_nxt;
    logic [AW-1:0]      ptr;
    logic               sweeping;
    logic               last;
    logic               wvalid;
    logic [W-1:0]       bank [DEPTH];
    logic [DEPTH*W-1:0] bank_flat;
    logic [W-1:0]       cnst;
    logic [W-1:0]       wword;
    logic [W-1:0]       rd [NRD];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st <= ST_IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    always_comb begin
        st_nxt = st;
        unique case (st)
            ST_IDLE:  if (bus.clr) st_nxt = ST_CLEAR;
            ST_CLEAR: if (last) st_nxt = ST_IDLE;
            default:  st_nxt = ST_IDLE;
        endcase
    end

    // Outputs decode the state register only, so busy is glitch-free.
    always_comb begin
        sweeping = (st == ST_CLEAR);
        last     = (ptr == AW'(DEPTH - 1));
        wvalid   = bus.regwen && (st == ST_IDLE) && !bus.clr;
    end

    assign bus.busy = sweeping;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (sweeping) begin
            ptr <= ptr + AW'(1);
        end else begin
            ptr <= '0;
        end
    end

    always_comb begin
        wword = W'(merge_word(wide_t'(bank[bus.selwreg]),
                              wide_t'(bus.inA),
                              bus.endreg, W));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (sweeping) begin
            bank[ptr] <= '0;
        end else if (wvalid) begin
            bank[bus.selwreg] <= wword;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnst <= '0;
        end else if (bus.cnstwen) begin
            cnst <= bus.inA;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
        assign bank_flat[i*W +: W] = bank[i];
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        regbank_mp_rdport #(
            .W      (W),
            .DEPTH  (DEPTH),
            .BYPASS (BYPASS),
            .AW     (AW)
        ) u_rd (
            .clock     (clock),
            .reset     (reset),
            .bank_flat (bank_flat),
            .cnst      (cnst),
            .cnst_new  (bus.inA),
            .cnst_we   (bus.cnstwen),
            .wword     (wword),
            .wsel      (bus.selwreg),
            .wvalid    (wvalid),
            .rsel      (bus.rsel[p*AW +: AW]),
            .rcnst     (bus.rcnst[p]),
            .ren       (bus.ren[p]),
            .rdata     (rd[p])
        );
        assign bus.rdata[p*W +: W] = rd[p];
    end

endmodule
